// File: rtl/acc16_decode.sv
// Decode/operand-fetch stage for the 16-bit Hack accumulator pipeline.
// Define ACC16_DECODE_FWD_EN to release hazards early and bypass operands from writeback.
module acc16_decode #(
    parameter int WIDTH  = 16,
    parameter int PEND_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [15:0]      if_instr,
    output logic             id_ready,
    output logic             mem_req,
    output logic [14:0]      mem_addr,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_rvalid,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [5:0]       cb_EX,
    output logic [WIDTH-1:0] x_EX,
    output logic [WIDTH-1:0] y_EX,
    output logic [2:0]       dest_EX,
    output logic [2:0]       jmp_EX,
    output logic [WIDTH-1:0] a_EX,
    input  logic             wb_a_we,
    input  logic             wb_d_we,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             flush
);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    state_t            state;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  d_reg;
    logic [PEND_W-1:0] a_pend;
    logic [PEND_W-1:0] d_pend;
    logic [5:0]        hold_cb;
    logic [2:0]        hold_dest;
    logic [2:0]        hold_jmp;

    logic             is_c;
    logic             a_busy;
    logic             d_busy;
    logic             ex_free;
    logic             c_ok;
    logic             accept;
    logic             load_c0;
    logic             load_mem;
    logic             load;
    logic             mem_go;
    logic [WIDTH-1:0] a_op;
    logic [WIDTH-1:0] d_op;
    logic [5:0]       ld_cb;
    logic [2:0]       ld_dest;
    logic [2:0]       ld_jmp;
    logic [WIDTH-1:0] ld_y;
    logic             a_inc;
    logic             d_inc;
    logic             a_kill;
    logic             d_kill;

`ifdef ACC16_DECODE_FWD_EN
    // A single outstanding writer retiring this cycle no longer blocks.
    assign a_busy = (a_pend != '0) && !((a_pend == PEND_ONE) && wb_a_we);
    assign d_busy = (d_pend != '0) && !((d_pend == PEND_ONE) && wb_d_we);
    assign a_op   = wb_a_we ? wb_data : a_reg;
    assign d_op   = wb_d_we ? wb_data : d_reg;
`else
    assign a_busy = (a_pend != '0);
    assign d_busy = (d_pend != '0);
    assign a_op   = a_reg;
    assign d_op   = d_reg;
`endif

    assign is_c    = if_instr[15];
    assign ex_free = !ex_valid || ex_ready;
    assign c_ok    = !a_busy && !d_busy && ex_free
                   && !(if_instr[5] && (a_pend == PEND_MAX))
                   && !(if_instr[4] && (d_pend == PEND_MAX));

    assign id_ready = !flush && (state == IDLE) && (is_c ? c_ok : !a_busy);
    assign accept   = if_valid && id_ready;
    assign load_c0  = accept && is_c && !if_instr[12];
    assign mem_go   = accept && is_c && if_instr[12];
    assign load_mem = (state == WAIT_MEM) && mem_rvalid && ex_free && !flush;
    assign load     = load_c0 || load_mem;

    assign ld_cb   = load_mem ? hold_cb   : if_instr[11:6];
    assign ld_dest = load_mem ? hold_dest : if_instr[5:3];
    assign ld_jmp  = load_mem ? hold_jmp  : if_instr[2:0];
    assign ld_y    = load_mem ? mem_rdata : a_op;

    assign a_inc  = load && ld_dest[2];
    assign d_inc  = load && ld_dest[1];
    // A killed entry that EX never took will never write back.
    assign a_kill = flush && ex_valid && !ex_ready && dest_EX[2];
    assign d_kill = flush && ex_valid && !ex_ready && dest_EX[1];

    assign mem_addr = a_reg[14:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            d_reg     <= '0;
            a_pend    <= '0;
            d_pend    <= '0;
            hold_cb   <= '0;
            hold_dest <= '0;
            hold_jmp  <= '0;
            mem_req   <= 1'b0;
            ex_valid  <= 1'b0;
            cb_EX     <= '0;
            x_EX      <= '0;
            y_EX      <= '0;
            dest_EX   <= '0;
            jmp_EX    <= '0;
            a_EX      <= '0;
        end else begin
            mem_req <= mem_go;

            if (wb_a_we)
                a_reg <= wb_data;
            if (accept && !is_c)
                a_reg <= WIDTH'({1'b0, if_instr[14:0]});
            if (wb_d_we)
                d_reg <= wb_data;

            a_pend <= a_pend + PEND_W'(a_inc)
                    - PEND_W'(wb_a_we) - PEND_W'(a_kill);
            d_pend <= d_pend + PEND_W'(d_inc)
                    - PEND_W'(wb_d_we) - PEND_W'(d_kill);

            if (mem_go) begin
                hold_cb   <= if_instr[11:6];
                hold_dest <= if_instr[5:3];
                hold_jmp  <= if_instr[2:0];
            end

            unique case (state)
                IDLE:     if (mem_go) state <= WAIT_MEM;
                WAIT_MEM: if (flush || load_mem) state <= IDLE;
            endcase

            if (flush) begin
                ex_valid <= 1'b0;
            end else if (load) begin
                ex_valid <= 1'b1;
                cb_EX    <= ld_cb;
                x_EX     <= d_op;
                y_EX     <= ld_y;
                dest_EX  <= ld_dest;
                jmp_EX   <= ld_jmp;
                a_EX     <= a_op;
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_acc16_decode.sv
// Bench for acc16_decode: directed scenarios, then random programs
// checked against an in-order architectural model of A, D and memory.
module tb_acc16_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [15:0] if_instr;
    logic        id_ready;
    logic        mem_req;
    logic [14:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic        ex_valid;
    logic        ex_ready;
    logic [5:0]  cb_EX;
    logic [15:0] x_EX;
    logic [15:0] y_EX;
    logic [2:0]  dest_EX;
    logic [2:0]  jmp_EX;
    logic [15:0] a_EX;
    logic        wb_a_we;
    logic        wb_d_we;
    logic [15:0] wb_data;
    logic        flush;

    always #5 clk = ~clk;

    acc16_decode #(.WIDTH(16), .PEND_W(2)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_instr(if_instr), .id_ready(id_ready),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .cb_EX(cb_EX), .x_EX(x_EX), .y_EX(y_EX),
        .dest_EX(dest_EX), .jmp_EX(jmp_EX), .a_EX(a_EX),
        .wb_a_we(wb_a_we), .wb_d_we(wb_d_we), .wb_data(wb_data),
        .flush(flush)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Memory contents as a fixed function of the address.
    function automatic logic [15:0] memf(input logic [14:0] a);
        return {a[6:0], a[14:7], 1'b1} ^ 16'h5A3C;
    endfunction

    typedef struct packed {
        logic [5:0]  cb;
        logic [2:0]  dest;
        logic [2:0]  jmp;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] aex;
    } exp_t;

    exp_t        expq[$];
    exp_t        e;
    logic [15:0] prog[$];
    logic [15:0] w;
    logic [15:0] m_a;
    logic [15:0] m_d;
    logic [15:0] wb_val;
    logic        wb_pa;
    logic        wb_pd;
    int          wb_cnt;
    int          rsp_cnt;
    logic [14:0] rsp_addr;
    int          pi;
    logic        take;
    logic        drop_rv;

    initial begin
        rst = 1; if_valid = 0; if_instr = 0; mem_rdata = 0;
        mem_rvalid = 0; ex_ready = 0; wb_a_we = 0; wb_d_we = 0;
        wb_data = 0; flush = 0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_cb", cb_EX, 0);
        chk("rst_x", x_EX, 0);
        chk("rst_y", y_EX, 0);
        chk("rst_a_ex", a_EX, 0);
        chk("rst_dest_jmp", {dest_EX, jmp_EX}, 0);

        // A-instruction 0x0005
        @(negedge clk); rst = 0; if_valid = 1; if_instr = 16'h0005;
        #1 chk("a_ready", id_ready, 1);
        @(negedge clk); if_instr = 16'hE010;
        #1 chk("a_no_issue", ex_valid, 0);
        chk("c_ready_after_a", id_ready, 1);
        @(negedge clk); if_valid = 0; ex_ready = 1;
        #1 chk("c0_valid", ex_valid, 1);
        chk("c0_y_is_a5", y_EX, 16'h0005);
        chk("c0_dest", dest_EX, 3'b010);
        @(negedge clk); wb_d_we = 1; wb_data = 16'h0003;
        #1 chk("ex_drop", ex_valid, 0);

        // 0xE090 with A=5, D=3
        @(negedge clk); wb_d_we = 0; if_valid = 1; if_instr = 16'hE090;
        #1 chk("e090_ready", id_ready, 1);
        @(negedge clk);
        #1 chk("e090_valid", ex_valid, 1);
        chk("e090_cb", cb_EX, 6'b000010);
        chk("e090_x", x_EX, 16'h0003);
        chk("e090_y", y_EX, 16'h0005);
        chk("e090_dest", dest_EX, 3'b010);
        chk("dep_stall", id_ready, 0);
        @(negedge clk); wb_d_we = 1; wb_data = 16'h0008;
`ifdef ACC16_DECODE_FWD_EN
        #1 chk("dep_wb_cycle", id_ready, 1);
        @(negedge clk); wb_d_we = 0; if_valid = 0;
        #1 chk("dep_valid", ex_valid, 1);
        chk("dep_x", x_EX, 16'h0008);
`else
        #1 chk("dep_wb_cycle", id_ready, 0);
        @(negedge clk); wb_d_we = 0;
        #1 chk("dep_after_wb", id_ready, 1);
        @(negedge clk); if_valid = 0;
        #1 chk("dep_valid", ex_valid, 1);
        chk("dep_x", x_EX, 16'h0008);
`endif
        @(negedge clk); wb_d_we = 1; wb_data = 16'h0008;
        @(negedge clk); wb_d_we = 0; if_valid = 1; if_instr = 16'h0010;
        #1 chk("a10_ready", id_ready, 1);

        // M operand read with A=0x0010
        @(negedge clk); if_instr = 16'hF1C7; ex_ready = 0;
        #1 chk("mem_ready", id_ready, 1);
        @(negedge clk); if_instr = 16'h0001;
        #1 chk("mem_req", mem_req, 1);
        chk("mem_addr", mem_addr, 15'h0010);
        chk("wait_blk", id_ready, 0);
        @(negedge clk); if_valid = 0;
        #1 chk("req_pulse", mem_req, 0);
        @(negedge clk); mem_rvalid = 1; mem_rdata = 16'h1234;
        @(negedge clk); mem_rvalid = 0; if_valid = 1; if_instr = 16'hE090;
        #1 chk("m_a_ex", a_EX, 16'h0010);
        chk("m_jmp", jmp_EX, 3'b111);
        chk("m_dest", dest_EX, 3'b000);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1 chk("hold_valid", ex_valid, 1);
            chk("hold_y", y_EX, 16'h1234);
            chk("hold_cb", cb_EX, 6'b000111);
            chk("hold_x", x_EX, 16'h0008);
            chk("hold_blk", id_ready, 0);
        end
        @(negedge clk); ex_ready = 1;
        #1 chk("release", id_ready, 1);

        // flush of an unconsumed D writer
        @(negedge clk); ex_ready = 0; flush = 1;
        #1 chk("fl_valid", ex_valid, 1);
        chk("fl_y", y_EX, 16'h0010);
        chk("fl_dest", dest_EX, 3'b010);
        chk("flush_blk", id_ready, 0);
        @(negedge clk); flush = 0; if_instr = 16'hF1C7;
        #1 chk("flush_kill", ex_valid, 0);
        chk("dpend_clr", id_ready, 1);
        @(negedge clk); if_valid = 0; flush = 1;
        #1 chk("fl_mem_req", mem_req, 1);
        @(negedge clk); flush = 0; mem_rvalid = 1; mem_rdata = 16'hBEEF;
        ex_ready = 1; if_valid = 1; if_instr = 16'h0003;
        #1 chk("abort_idle", id_ready, 1);
        chk("abort_noload", ex_valid, 0);
        @(negedge clk); if_valid = 0;
        #1 chk("late_ign1", ex_valid, 0);
        @(negedge clk); mem_rvalid = 0;
        #1 chk("late_ign2", ex_valid, 0);

        // reset during WAIT_MEM
        @(negedge clk); if_valid = 1; if_instr = 16'hF1C7; ex_ready = 0;
        #1 chk("r_ready", id_ready, 1);
        @(negedge clk); if_valid = 0; rst = 1;
        #1 chk("r_mem_req", mem_req, 1);
        chk("r_mem_addr", mem_addr, 15'h0003);
        @(negedge clk); rst = 0; mem_rvalid = 1; mem_rdata = 16'h0001;
        if_valid = 1; if_instr = 16'h0004;
        #1 chk("rst_idle", id_ready, 1);
        chk("rst_no_req", mem_req, 0);
        @(negedge clk); mem_rvalid = 0; if_valid = 0;
        #1 chk("rst_noload", ex_valid, 0);

        // random programs against the architectural model
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        m_a = 0; m_d = 0; wb_cnt = -1; rsp_cnt = -1;
        rsp_addr = 0; pi = 0; take = 0; drop_rv = 0;
        wb_val = 0; wb_pa = 0; wb_pd = 0;
        for (int i = 0; i < 160; i++) begin
            if ($urandom_range(9) < 4) w = {1'b0, 15'($urandom)};
            else w = {3'b111, 13'($urandom)};
            prog.push_back(w);
        end

        for (int cyc = 0; cyc < 8000; cyc++) begin
            @(negedge clk);
            if (take) begin if_valid = 0; take = 0; end
            if (drop_rv) begin mem_rvalid = 0; drop_rv = 0; end
            wb_a_we = 0; wb_d_we = 0;
            if (wb_cnt == 0) begin
                wb_a_we = wb_pa; wb_d_we = wb_pd; wb_data = wb_val;
                wb_cnt = -1;
            end else if (wb_cnt > 0) wb_cnt--;
            if (rsp_cnt == 0) begin
                mem_rvalid = 1; mem_rdata = memf(rsp_addr); rsp_cnt = -1;
            end else if (rsp_cnt > 0) rsp_cnt--;
            ex_ready = ($urandom_range(3) != 0);
            if (!if_valid && pi < prog.size() && $urandom_range(2) != 0) begin
                if_valid = 1; if_instr = prog[pi];
            end
            #1;
            if (ex_valid && ex_ready) begin
                if (expq.size() == 0) chk("rand_spurious", ex_valid, 0);
                else begin
                    e = expq.pop_front();
                    chk("rand_cb", cb_EX, e.cb);
                    chk("rand_dest", dest_EX, e.dest);
                    chk("rand_jmp", jmp_EX, e.jmp);
                    chk("rand_x", x_EX, e.x);
                    chk("rand_y", y_EX, e.y);
                    chk("rand_a_ex", a_EX, e.aex);
                    if (e.dest[2] || e.dest[1]) begin
                        wb_val = 16'($urandom);
                        wb_pa = e.dest[2]; wb_pd = e.dest[1];
                        wb_cnt = $urandom_range(2);
                        if (e.dest[2]) m_a = wb_val;
                        if (e.dest[1]) m_d = wb_val;
                    end
                end
            end
            if (if_valid && id_ready && !take) begin
                if (!if_instr[15]) m_a = {1'b0, if_instr[14:0]};
                else begin
                    e.cb = if_instr[11:6]; e.dest = if_instr[5:3];
                    e.jmp = if_instr[2:0]; e.x = m_d; e.aex = m_a;
                    e.y = if_instr[12] ? memf(m_a[14:0]) : m_a;
                    expq.push_back(e);
                end
                pi++; take = 1;
            end
            if (mem_req) begin
                chk("rand_maddr", mem_addr, m_a[14:0]);
                rsp_addr = mem_addr; rsp_cnt = $urandom_range(2);
            end
            if (mem_rvalid && (!ex_valid || ex_ready)) drop_rv = 1;
            if (pi == prog.size() && expq.size() == 0 && wb_cnt < 0) break;
        end
        @(negedge clk); if_valid = 0;
        chk("rand_issued", pi, prog.size());
        chk("rand_drained", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
